// File: rtl/cap_array_seq.sv
// cap_array_seq: ramps a 0..256 capacitor count toward a requested target,
// settles, then pulses done. The count is thermometer-encoded onto a 16x16
// cell array (column off/on controls plus odd/even row controls).
//
// Parameters:
//   STEP       - maximum count change per ramp cycle (1..256)
//   SETTLE_CYC - settle cycles after the target is reached (1..255)
// Ports:
//   clk, rst           - clock (rising edge), asynchronous active-high reset
//   req_valid          - a new target is offered
//   req_target[8:0]    - requested count (clamped to 256)
//   req_ready          - request can be accepted this cycle
//   col_off/col_on     - array column controls
//   row_p/row_n        - row controls for odd/even partial column
//   cur_count[8:0]     - count currently driven to the array
//   busy               - ramping or settling
//   done               - one-cycle completion pulse
// Build option:
//   CAP_ARRAY_SEQ_RETARGET_EN - accept a new target while ramping/settling
module cap_array_seq #(
  parameter int unsigned STEP       = 1,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [8:0]  req_target,
  output logic        req_ready,
  output logic [15:0] col_off,
  output logic [15:0] col_on,
  output logic [15:0] row_p,
  output logic [15:0] row_n,
  output logic [8:0]  cur_count,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW   = 9;
  localparam int unsigned NCOL = 16;
  localparam logic [CW-1:0] STEP_V   = CW'(STEP);
  localparam logic [CW-1:0] MAX_CNT  = CW'(256);
  localparam logic [7:0]    SET_LAST = 8'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, RAMP, SETTLE, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   target_q, target_d;
  logic [7:0]      set_cnt_q, set_cnt_d;

  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [15:0]     col_off_q, col_off_d;
  logic [15:0]     col_on_q, col_on_d;
  logic [15:0]     row_p_q, row_p_d;
  logic [15:0]     row_n_q, row_n_d;

  logic            accept;
  logic [CW-1:0]   req_clamped;
  logic            up;
  logic [CW-1:0]   diff;
  logic [CW-1:0]   step_amt;
  logic [4:0]      f_col;
  logic [3:0]      r_rem;
  logic [15:0]     row_mask;

  // Next state, count and registered-output values
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    target_d  = target_q;
    set_cnt_d = set_cnt_q;

    accept      = req_valid && ready_q;
    req_clamped = (req_target > MAX_CNT) ? MAX_CNT : req_target;
    up          = (target_q > count_q);
    diff        = up ? (target_q - count_q) : (count_q - target_q);
    step_amt    = (diff < STEP_V) ? diff : STEP_V;

    case (state_q)
      IDLE: begin
        if (accept) begin
          target_d = req_clamped;
          state_d  = RAMP;
        end
      end
      RAMP: begin
        if (count_q == target_q) begin
          state_d   = SETTLE;
          set_cnt_d = 8'd0;
        end else begin
          // step never exceeds the remaining distance, so no overshoot/wrap
          count_d = up ? (count_q + step_amt) : (count_q - step_amt);
          if (count_d == target_q) begin
            state_d   = SETTLE;
            set_cnt_d = 8'd0;
          end
        end
      end
      SETTLE: begin
        if (set_cnt_q == SET_LAST) begin
          state_d = DONE;
        end else begin
          set_cnt_d = set_cnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef CAP_ARRAY_SEQ_RETARGET_EN
    // Mid-operation retarget: count holds on the acceptance edge
    if (accept && (state_q == RAMP || state_q == SETTLE)) begin
      target_d  = req_clamped;
      count_d   = count_q;
      set_cnt_d = 8'd0;
      state_d   = RAMP;
    end
    ready_d = (state_d == IDLE) || (state_d == RAMP) || (state_d == SETTLE);
`else
    ready_d = (state_d == IDLE);
`endif
    busy_d = (state_d == RAMP) || (state_d == SETTLE);
    done_d = (state_d == DONE);

    // Array code for the next count: full columns below F, partial column F
    f_col     = count_d[8:4];
    r_rem     = count_d[3:0];
    row_mask  = (16'd1 << r_rem) - 16'd1;
    col_off_d = '1;
    col_on_d  = '0;
    for (int unsigned c = 0; c < NCOL; c++) begin
      if (5'(c) < f_col) begin
        col_off_d[c] = 1'b0;
      end else if (5'(c) == f_col) begin
        col_on_d[c] = (r_rem != 4'd0);
      end
    end
    row_p_d = '0;
    row_n_d = '0;
    if (!f_col[4]) begin
      if (f_col[0]) row_p_d = row_mask;
      else          row_n_d = row_mask;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      target_q  <= '0;
      set_cnt_q <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      col_off_q <= 16'hFFFF;
      col_on_q  <= '0;
      row_p_q   <= '0;
      row_n_q   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      target_q  <= target_d;
      set_cnt_q <= set_cnt_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      col_off_q <= col_off_d;
      col_on_q  <= col_on_d;
      row_p_q   <= row_p_d;
      row_n_q   <= row_n_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cur_count = count_q;
  assign col_off   = col_off_q;
  assign col_on    = col_on_q;
  assign row_p     = row_p_q;
  assign row_n     = row_n_q;

endmodule

// File: tb/tb_cap_array_seq.sv
// Scoreboard bench for cap_array_seq: instance A (STEP=1) and B (STEP=4).
module tb_cap_array_seq;

  typedef struct packed {
    logic        dn;
    logic [8:0]  cnt;
    logic [15:0] c_off;
    logic [15:0] c_on;
    logic [15:0] rp;
    logic [15:0] rn;
    logic [15:0] lat;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b0, valid_a = 1'b0, ready_a, busy_a, done_a;
  logic [8:0]  target_a = '0, cur_a;
  logic [15:0] off_a, on_a, rp_a, rn_a;
  logic        rst_b = 1'b0, valid_b = 1'b0, ready_b, busy_b, done_b;
  logic [8:0]  target_b = '0, cur_b;
  logic [15:0] off_b, on_b, rp_b, rn_b;

  cap_array_seq #(.STEP(1), .SETTLE_CYC(4)) u_a (
    .clk(clk), .rst(rst_a), .req_valid(valid_a), .req_target(target_a),
    .req_ready(ready_a), .col_off(off_a), .col_on(on_a), .row_p(rp_a),
    .row_n(rn_a), .cur_count(cur_a), .busy(busy_a), .done(done_a));

  cap_array_seq #(.STEP(4), .SETTLE_CYC(4)) u_b (
    .clk(clk), .rst(rst_b), .req_valid(valid_b), .req_target(target_b),
    .req_ready(ready_b), .col_off(off_b), .col_on(on_b), .row_p(rp_b),
    .row_n(rn_b), .cur_count(cur_b), .busy(busy_b), .done(done_b));

  int  n_vec = 0;
  int  n_err = 0;
  ev_t qa[$];
  ev_t qb[$];

  function automatic ev_t mk(input logic dn, input logic [8:0] cnt,
                             input logic [15:0] c_off, input logic [15:0] c_on,
                             input logic [15:0] rp, input logic [15:0] rn,
                             input logic [15:0] lat);
    ev_t e;
    e.dn = dn; e.cnt = cnt; e.c_off = c_off; e.c_on = c_on;
    e.rp = rp; e.rn = rn; e.lat = lat;
    return e;
  endfunction

  // Active cells: 16 per fully-on column plus the row cells of the partial column
  function automatic int cells(input ev_t a);
    int n = 0;
    for (int c = 0; c < 16; c++) if (!a.c_off[c]) n += 16;
    if (a.c_on != 16'd0) n += $countones(a.rp | a.rn);
    return n;
  endfunction

  task automatic check_ev(input string nm, input bit have, input ev_t e, input ev_t a);
    n_vec++;
    if (!have) begin
      n_err++;
      $display("FAIL %s unexpected event: got cnt=%0d done=%0b, queue empty", nm, a.cnt, a.dn);
    end else if (a.dn !== e.dn || a.cnt !== e.cnt) begin
      n_err++;
      $display("FAIL %s event: got cnt=%0d done=%0b, want cnt=%0d done=%0b",
               nm, a.cnt, a.dn, e.cnt, e.dn);
    end else if (e.dn && ({a.c_off, a.c_on, a.rp, a.rn, a.lat} !==
                          {e.c_off, e.c_on, e.rp, e.rn, e.lat})) begin
      n_err++;
      $display("FAIL %s done code: got off=%h on=%h rp=%h rn=%h lat=%0d, want off=%h on=%h rp=%h rn=%h lat=%0d",
               nm, a.c_off, a.c_on, a.rp, a.rn, a.lat, e.c_off, e.c_on, e.rp, e.rn, e.lat);
    end
    n_vec++;
    if (cells(a) != int'(a.cnt)) begin
      n_err++;
      $display("FAIL %s cells: got %0d cells, want %0d", nm, cells(a), a.cnt);
    end
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Latency counters: edges since the last accepted request
  int lat_a = 0, lat_b = 0;
  initial forever begin
    @(posedge clk);
    lat_a = (valid_a && ready_a) ? 0 : lat_a + 1;
    lat_b = (valid_b && ready_b) ? 0 : lat_b + 1;
  end

  // Monitor A: an event is any count change or a done pulse
  logic [8:0] prev_a = '0;
  logic       dprev_a = 1'b0;
  bit         have_a;
  ev_t        e_a;
  initial forever begin
    @(negedge clk);
    if (rst_a) begin
      prev_a = cur_a;
    end else begin
      if (cur_a !== prev_a || done_a === 1'b1) begin
        have_a = (qa.size() != 0);
        if (have_a) e_a = qa.pop_front(); else e_a = '0;
        check_ev("A", have_a, e_a, mk(done_a, cur_a, off_a, on_a, rp_a, rn_a, 16'(lat_a)));
      end
      if (dprev_a) begin
        n_vec++;
        if (done_a !== 1'b0) begin
          n_err++;
          $display("FAIL A done_width: got done=%b on 2nd cycle, want 0", done_a);
        end
      end
      prev_a = cur_a;
    end
    dprev_a = rst_a ? 1'b0 : (done_a === 1'b1);
  end

  // Monitor B
  logic [8:0] prev_b = '0;
  bit         have_b;
  ev_t        e_b;
  initial forever begin
    @(negedge clk);
    if (rst_b) begin
      prev_b = cur_b;
    end else begin
      if (cur_b !== prev_b || done_b === 1'b1) begin
        have_b = (qb.size() != 0);
        if (have_b) e_b = qb.pop_front(); else e_b = '0;
        check_ev("B", have_b, e_b, mk(done_b, cur_b, off_b, on_b, rp_b, rn_b, 16'(lat_b)));
      end
      prev_b = cur_b;
    end
  end

  task automatic push_ramp_a(input int from, input int to);
    if (to > from) for (int v = from + 1; v <= to; v++) qa.push_back(mk(1'b0, 9'(v), '0, '0, '0, '0, '0));
    else           for (int v = from - 1; v >= to; v--) qa.push_back(mk(1'b0, 9'(v), '0, '0, '0, '0, '0));
  endtask

  task automatic send_a(input logic [8:0] t);
    @(posedge clk); #1;
    valid_a = 1'b1; target_a = t;
    @(posedge clk); #1;
    valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [8:0] t);
    @(posedge clk); #1;
    valid_b = 1'b1; target_b = t;
    @(posedge clk); #1;
    valid_b = 1'b0;
  endtask

  task automatic wait_idle_a(input string nm);
    int k = 0;
    do begin @(negedge clk); k++; end while (!(qa.size() == 0 && ready_a === 1'b1) && k < 2000);
    cmp({nm, "_timeout"}, 32'(k >= 2000), 32'd0);
  endtask

  task automatic wait_idle_b(input string nm);
    int k = 0;
    do begin @(negedge clk); k++; end while (!(qb.size() == 0 && ready_b === 1'b1) && k < 2000);
    cmp({nm, "_timeout"}, 32'(k >= 2000), 32'd0);
  endtask

  task automatic wait_cnt_a(input logic [8:0] v, input string nm);
    int k = 0;
    do begin @(negedge clk); k++; end while (cur_a !== v && k < 500);
    cmp({nm, "_timeout"}, 32'(k >= 500), 32'd0);
  endtask

  task automatic check_reset_a(input string nm);
    cmp({nm, "_cnt"},   32'(cur_a),   32'd0);
    cmp({nm, "_off"},   32'(off_a),   32'h0000FFFF);
    cmp({nm, "_on"},    32'(on_a),    32'd0);
    cmp({nm, "_rp"},    32'(rp_a),    32'd0);
    cmp({nm, "_rn"},    32'(rn_a),    32'd0);
    cmp({nm, "_busy"},  32'(busy_a),  32'd0);
    cmp({nm, "_done"},  32'(done_a),  32'd0);
    cmp({nm, "_ready"}, 32'(ready_a), 32'd0);
  endtask

  task automatic seq_a();
    #1 rst_a = 1'b1;
    #1 check_reset_a("rst0");
    @(negedge clk); rst_a = 1'b0;
    @(posedge clk); #1;
    cmp("rst0_ready_after", 32'(ready_a), 32'd1);

    // Up-ramp 0 -> 37
    push_ramp_a(0, 37);
    qa.push_back(mk(1'b1, 9'd37, 16'hFFFC, 16'h0004, 16'h0000, 16'h001F, 16'd41));
    send_a(9'd37);
`ifndef CAP_ARRAY_SEQ_RETARGET_EN
    // Requests offered mid-ramp must be ignored
    valid_a = 1'b1; target_a = 9'd3;
    repeat (10) @(posedge clk);
    #1 valid_a = 1'b0;
`endif
    wait_idle_a("up37");

    // Equal target: one RAMP cycle then SETTLE, code unchanged
    qa.push_back(mk(1'b1, 9'd37, 16'hFFFC, 16'h0004, 16'h0000, 16'h001F, 16'd5));
    send_a(9'd37);
    wait_idle_a("eq37");

    // Down to 16 then 16 -> 0
    push_ramp_a(37, 16);
    qa.push_back(mk(1'b1, 9'd16, 16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 16'd25));
    send_a(9'd16);
    wait_idle_a("dn16");
    push_ramp_a(16, 0);
    qa.push_back(mk(1'b1, 9'd0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'd20));
    send_a(9'd0);
    wait_idle_a("dn0");

    // Odd partial column
    push_ramp_a(0, 20);
    qa.push_back(mk(1'b1, 9'd20, 16'hFFFE, 16'h0002, 16'h000F, 16'h0000, 16'd24));
    send_a(9'd20);
    wait_idle_a("up20");

    // Reset mid-ramp at count 9, ramp must be abandoned
    push_ramp_a(20, 0);
    send_a(9'd0);
    wait_cnt_a(9'd9, "to9");
    #2 rst_a = 1'b1;
    #1 check_reset_a("rst9");
    qa.delete();
    @(negedge clk); rst_a = 1'b0;
    #1 cmp("rst9_ready_low", 32'(ready_a), 32'd0);
    @(posedge clk); #1;
    cmp("rst9_ready_after", 32'(ready_a), 32'd1);
    repeat (6) @(negedge clk);
    cmp("rst9_abandon_cnt", 32'(cur_a), 32'd0);
    cmp("rst9_abandon_busy", 32'(busy_a), 32'd0);

`ifdef CAP_ARRAY_SEQ_RETARGET_EN
    // Retarget 100 -> 5 at count 10
    push_ramp_a(0, 10);
    push_ramp_a(10, 5);
    qa.push_back(mk(1'b1, 9'd5, 16'hFFFF, 16'h0001, 16'h0000, 16'h001F, 16'd9));
    send_a(9'd100);
    wait_cnt_a(9'd10, "rt10");
    valid_a = 1'b1; target_a = 9'd5;
    @(posedge clk); #1 valid_a = 1'b0;
    wait_idle_a("rt5");
`endif
  endtask

  task automatic seq_b();
    #1 rst_b = 1'b1;
    @(negedge clk); rst_b = 1'b0;
    // 0 -> 250 in steps of 4 (last step 2)
    for (int v = 4; v <= 248; v += 4) qb.push_back(mk(1'b0, 9'(v), '0, '0, '0, '0, '0));
    qb.push_back(mk(1'b0, 9'd250, '0, '0, '0, '0, '0));
    qb.push_back(mk(1'b1, 9'd250, 16'h8000, 16'h8000, 16'h03FF, 16'h0000, 16'd67));
    send_b(9'd250);
    wait_idle_b("b250");
    // 300 clamps to 256
    qb.push_back(mk(1'b0, 9'd254, '0, '0, '0, '0, '0));
    qb.push_back(mk(1'b0, 9'd256, '0, '0, '0, '0, '0));
    qb.push_back(mk(1'b1, 9'd256, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'd6));
    send_b(9'd300);
    wait_idle_b("b256");
  endtask

  initial begin
    fork
      seq_a();
      seq_b();
    join
    repeat (3) @(negedge clk);
    cmp("qa_drained", 32'(qa.size()), 32'd0);
    cmp("qb_drained", 32'(qb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d errors=%0d", n_vec, n_err);
    $fatal(1);
  end

endmodule
